// File: rtl/player_pkg.sv
`default_nettype none
// ============================================================
// Module   : player_pkg
// Brief    : shared types and constants for the playback core
// Revision : 1.0
// ============================================================
package player_pkg;

    typedef enum logic [1:0] {
        ST_PAUSED  = 2'd0,
        ST_PLAYING = 2'd1,
        ST_STOPPED = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_NORMAL     = 2'd0,
        MODE_REPEAT_ALL = 2'd1,
        MODE_REPEAT_ONE = 2'd2,
        MODE_SHUFFLE    = 2'd3
    } mode_t;

    localparam logic [7:0] c_END_MARK  = 8'hFF;
    localparam logic [7:0] c_LFSR_SEED = 8'hA5;
    localparam logic [9:0] c_SEC_MAX   = 10'd599;

    // Fibonacci form of x^8+x^6+x^5+x^4+1, shifting toward the MSB
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/player_if.sv
`default_nettype none
// ============================================================
// Module   : player_if
// Brief    : button/sample inputs and ROM/display outputs of the core
// Revision : 1.0
// ============================================================
interface player_if #(
    parameter int SONG_W = 2,
    parameter int ADDR_W = 22
) ();

    logic                     sample_en;
    logic [7:0]               data_in;
    logic                     play_pause;
    logic                     next_song;
    logic                     prev_song;
    logic                     mode_btn;
    logic                     fwd_short;
    logic                     back_short;
    logic                     fwd_long;
    logic                     back_long;
    logic [SONG_W+ADDR_W-1:0] addr;
    logic [SONG_W-1:0]        song;
    logic                     playing;
    logic [1:0]               mode;
    logic [3:0]               minutes0;
    logic [3:0]               seconds1;
    logic [3:0]               seconds0;
    logic                     song_start;

    modport master (
        output sample_en, data_in, play_pause, next_song, prev_song, mode_btn,
               fwd_short, back_short, fwd_long, back_long,
        input  addr, song, playing, mode, minutes0, seconds1, seconds0, song_start
    );

    modport slave (
        input  sample_en, data_in, play_pause, next_song, prev_song, mode_btn,
               fwd_short, back_short, fwd_long, back_long,
        output addr, song, playing, mode, minutes0, seconds1, seconds0, song_start
    );

endinterface
`default_nettype wire

// File: rtl/sec_to_bcd.sv
`default_nettype none
// ============================================================
// Module   : sec_to_bcd
// Brief    : binary seconds 0..599 to BCD m:ss digits (combinational)
// Revision : 1.0
// ============================================================
module sec_to_bcd (
    input  wire logic [9:0] i_sec,
    output logic      [3:0] o_minutes0,
    output logic      [3:0] o_seconds1,
    output logic      [3:0] o_seconds0
);

    logic [9:0] w_min;
    logic [9:0] w_rem;
    logic [9:0] w_tens;
    logic [3:0] w_ones;

    always_comb begin
        w_min  = i_sec / 10'd60;
        w_rem  = i_sec - w_min * 10'd60;
        w_tens = w_rem / 10'd10;
        w_ones = 4'(w_rem - w_tens * 10'd10);
    end

    assign o_minutes0 = w_min[3:0];
    assign o_seconds1 = w_tens[3:0];
    assign o_seconds0 = w_ones;

endmodule
`default_nettype wire

// File: rtl/player_core.sv
`default_nettype none
// ============================================================
// Module   : player_core
// Brief    : playback controller - song, sample address, time, mode
// Revision : 1.0
// ============================================================
module player_core
    import player_pkg::*;
#(
    parameter int         SONG_W      = 2,
    parameter int         ADDR_W      = 22,
    parameter int         SAMPLE_RATE = 8000,
    parameter int         SEEK_SHORT  = 10,
    parameter int         SEEK_LONG   = 30,
    parameter logic [7:0] END_MARK    = c_END_MARK
) (
    input wire logic clk,
    input wire logic reset,
    player_if.slave  bus
);

    localparam int c_SUM_W  = ADDR_W + 32;
    localparam int c_FRAC_W = (SAMPLE_RATE > 1) ? $clog2(SAMPLE_RATE) : 1;

    localparam logic [c_SUM_W-1:0]  c_ADDR_MAX   = c_SUM_W'({ADDR_W{1'b1}});
    localparam logic [c_SUM_W-1:0]  c_STEP_SHORT = c_SUM_W'(SEEK_SHORT * SAMPLE_RATE);
    localparam logic [c_SUM_W-1:0]  c_STEP_LONG  = c_SUM_W'(SEEK_LONG * SAMPLE_RATE);
    localparam logic [10:0]         c_SEC_SHORT  = 11'(SEEK_SHORT);
    localparam logic [10:0]         c_SEC_LONG   = 11'(SEEK_LONG);
    localparam logic [c_FRAC_W-1:0] c_FRAC_LAST  = c_FRAC_W'(SAMPLE_RATE - 1);

    state_t              r_state;
    mode_t               r_mode;
    logic [SONG_W-1:0]   r_song;
    logic [ADDR_W-1:0]   r_addr;
    logic [c_FRAC_W-1:0] r_frac;
    logic [9:0]          r_sec;
    logic [7:0]          r_lfsr;
    logic                r_song_start;

    logic                w_seek_any;
    logic                w_seek_fwd;
    logic [c_SUM_W-1:0]  w_seek_step;
    logic [10:0]         w_seek_sec;
    logic [c_SUM_W-1:0]  w_fwd_sum;
    logic                w_fwd_over;
    logic [10:0]         w_sec_sum;
    logic [9:0]          w_sec_fwd;
    logic                w_back_clear;
    logic                w_natural_eos;
    logic                w_do_eos;
    logic [SONG_W-1:0]   w_song_inc;
    logic [SONG_W-1:0]   w_pick;
    logic [SONG_W-1:0]   w_adv_song;
    logic [SONG_W-1:0]   w_prev_target;
    logic                w_stop;
    logic [3:0]          w_minutes0;
    logic [3:0]          w_seconds1;
    logic [3:0]          w_seconds0;

    always_comb begin
        // forward beats back within a pair, long pair beats short pair
        w_seek_fwd  = 1'b0;
        w_seek_step = c_STEP_SHORT;
        w_seek_sec  = c_SEC_SHORT;
        if (bus.fwd_long) begin
            w_seek_fwd  = 1'b1;
            w_seek_step = c_STEP_LONG;
            w_seek_sec  = c_SEC_LONG;
        end else if (bus.back_long) begin
            w_seek_step = c_STEP_LONG;
            w_seek_sec  = c_SEC_LONG;
        end else if (bus.fwd_short) begin
            w_seek_fwd  = 1'b1;
        end

        w_seek_any = (r_state != ST_STOPPED) &&
                     (bus.fwd_long || bus.back_long || bus.fwd_short || bus.back_short);

        w_fwd_sum    = c_SUM_W'(r_addr) + w_seek_step;
        w_fwd_over   = w_fwd_sum > c_ADDR_MAX;
        w_sec_sum    = {1'b0, r_sec} + w_seek_sec;
        w_sec_fwd    = (w_sec_sum > {1'b0, c_SEC_MAX}) ? c_SEC_MAX : w_sec_sum[9:0];
        w_back_clear = ({1'b0, r_sec} < w_seek_sec) || (c_SUM_W'(r_addr) < w_seek_step);

        w_natural_eos = (r_state == ST_PLAYING) && bus.sample_en &&
                        ((bus.data_in == END_MARK) || (r_addr == {ADDR_W{1'b1}}));
        // a seek past the last address only counts if no song button outranks it
        w_do_eos = w_natural_eos ||
                   (w_seek_any && w_seek_fwd && w_fwd_over && !bus.next_song && !bus.prev_song);

        w_song_inc = r_song + 1'b1;
        w_pick     = r_lfsr[SONG_W-1:0];
        case (r_mode)
            MODE_REPEAT_ONE: w_adv_song = r_song;
            MODE_SHUFFLE:    w_adv_song = (w_pick == r_song) ? w_song_inc : w_pick;
            default:         w_adv_song = w_song_inc;
        endcase

        w_stop        = (r_mode == MODE_NORMAL) && (r_song == {SONG_W{1'b1}});
        w_prev_target = (r_sec >= 10'd3) ? r_song : r_song - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_PAUSED;
            r_mode       <= MODE_NORMAL;
            r_song       <= '0;
            r_addr       <= '0;
            r_frac       <= '0;
            r_sec        <= '0;
            r_lfsr       <= c_LFSR_SEED;
            r_song_start <= 1'b0;
        end else begin
            r_lfsr       <= lfsr_step(r_lfsr);
            r_song_start <= 1'b0;

            if (bus.mode_btn) begin
                r_mode <= mode_t'(r_mode + 2'd1);
            end

            if (bus.play_pause) begin
                case (r_state)
                    ST_PLAYING: r_state <= ST_PAUSED;
                    default:    r_state <= ST_PLAYING;
                endcase
            end

            if (w_do_eos) begin
                r_addr       <= '0;
                r_frac       <= '0;
                r_sec        <= '0;
                r_song_start <= 1'b1;
                if (w_stop) begin
                    r_song  <= '0;
                    r_state <= ST_STOPPED;
                end else begin
                    r_song  <= w_adv_song;
                end
            end else if (bus.next_song || bus.prev_song) begin
                r_song       <= bus.next_song ? w_adv_song : w_prev_target;
                r_addr       <= '0;
                r_frac       <= '0;
                r_sec        <= '0;
                r_song_start <= 1'b1;
            end else if (w_seek_any) begin
                if (w_seek_fwd) begin
                    r_addr <= w_fwd_sum[ADDR_W-1:0];
                    r_sec  <= w_sec_fwd;
                end else if (w_back_clear) begin
                    r_addr <= '0;
                    r_frac <= '0;
                    r_sec  <= '0;
                end else begin
                    r_addr <= r_addr - w_seek_step[ADDR_W-1:0];
                    r_sec  <= r_sec - w_seek_sec[9:0];
                end
            end else if ((r_state == ST_PLAYING) && bus.sample_en) begin
                r_addr <= r_addr + 1'b1;
                if (r_frac == c_FRAC_LAST) begin
                    r_frac <= '0;
                    if (r_sec != c_SEC_MAX) begin
                        r_sec <= r_sec + 10'd1;
                    end
                end else begin
                    r_frac <= r_frac + 1'b1;
                end
            end

            // leaving STOPPED always restarts from the top of song 0
            if (bus.play_pause && (r_state == ST_STOPPED)) begin
                r_song       <= '0;
                r_addr       <= '0;
                r_frac       <= '0;
                r_sec        <= '0;
                r_song_start <= 1'b1;
            end
        end
    end

    sec_to_bcd u_sec_to_bcd (
        .i_sec      (r_sec),
        .o_minutes0 (w_minutes0),
        .o_seconds1 (w_seconds1),
        .o_seconds0 (w_seconds0)
    );

    assign bus.addr       = {r_song, r_addr};
    assign bus.song       = r_song;
    assign bus.playing    = (r_state == ST_PLAYING);
    assign bus.mode       = r_mode;
    assign bus.song_start = r_song_start;
    assign bus.minutes0   = w_minutes0;
    assign bus.seconds1   = w_seconds1;
    assign bus.seconds0   = w_seconds0;

endmodule
`default_nettype wire
